// File: rtl/output_display_driver.sv
// output_display_driver: double-buffered 32-bit word shown on 8 multiplexed seven-segment digits, address on LEDs
module output_display_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter bit BLANK_LZ     = 1'b1,
  parameter int FLASH_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic [4:0]  addr_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [4:0]  led
);
  localparam int TW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam logic [15:0][6:0] HEX = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    digit_q, digit_d;
  logic          pend_full_q, pend_full_d;
  logic [31:0]   pend_word_q, pend_word_d, disp_word_q, disp_word_d;
  logic [4:0]    pend_addr_q, pend_addr_d, disp_addr_q, disp_addr_d;
  logic [FW-1:0] flash_q, flash_d;
  logic [7:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic [4:0]    led_q, led_d;
  logic          tick, frame, commit, accept, blank;
  logic [3:0]    nib;
  always_comb begin
    tick        = tick_q == TW'(SCAN_DIV - 1);
    frame       = tick && digit_q == 3'd7;
    commit      = frame && pend_full_q;
    accept      = data_valid && !pend_full_q;
    tick_d      = tick ? '0 : tick_q + 1'b1;
    digit_d     = tick ? digit_q + 3'd1 : digit_q;
    pend_full_d = accept ? 1'b1 : commit ? 1'b0 : pend_full_q;
    pend_word_d = accept ? data_in : pend_word_q;
    pend_addr_d = accept ? addr_in : pend_addr_q;
    disp_word_d = commit ? pend_word_q : disp_word_q;
    disp_addr_d = commit ? pend_addr_q : disp_addr_q;
    flash_d     = commit ? FW'(FLASH_FRAMES) : (frame && flash_q != '0) ? flash_q - 1'b1 : flash_q;
    // leading-zero test: everything at and above this digit is zero
    nib         = disp_word_q[{digit_q, 2'b00} +: 4];
    blank       = BLANK_LZ && digit_q != 3'd0 && (disp_word_q >> {digit_q, 2'b00}) == 32'd0;
    an_n_d      = blank ? 8'hFF : ~(8'd1 << digit_q);
    seg_n_d     = blank ? 7'h7F : HEX[nib];
    dp_n_d      = !(digit_q == 3'd0 && flash_q != '0);
    led_d       = disp_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q      <= '0;
      digit_q     <= '0;
      pend_full_q <= 1'b0;
      pend_word_q <= '0;
      pend_addr_q <= '0;
      disp_word_q <= '0;
      disp_addr_q <= '0;
      flash_q     <= '0;
      an_n_q      <= 8'hFF;
      seg_n_q     <= 7'h7F;
      dp_n_q      <= 1'b1;
      led_q       <= '0;
    end else begin
      tick_q      <= tick_d;
      digit_q     <= digit_d;
      pend_full_q <= pend_full_d;
      pend_word_q <= pend_word_d;
      pend_addr_q <= pend_addr_d;
      disp_word_q <= disp_word_d;
      disp_addr_q <= disp_addr_d;
      flash_q     <= flash_d;
      an_n_q      <= an_n_d;
      seg_n_q     <= seg_n_d;
      dp_n_q      <= dp_n_d;
      led_q       <= led_d;
    end
  end
  assign data_ready = ~pend_full_q;
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign led        = led_q;
endmodule

// File: tb/tb_output_display_driver.sv
// tb_output_display_driver: random and directed writes checked against a frame-level reference model
module tb_output_display_driver;
  localparam int S = 4;
  localparam int F = 2;
  logic        clk = 1'b0, rst_n = 1'b0, data_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0]  addr_in = '0;
  logic        data_ready, data_ready0, dp_n, dp_n0;
  logic [7:0]  an_n, an_n0;
  logic [6:0]  seg_n, seg_n0;
  logic [4:0]  led, led0;
  int checks = 0, errors = 0;
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          n, flash_m;
  logic [31:0] disp_m, pend_m;
  logic [4:0]  daddr_m, paddr_m;
  bit          pend_full_m, acc_m;
  logic [7:0]  e_an, e_an0;
  logic [6:0]  e_seg, e_seg0;
  logic        e_dp;
  logic [4:0]  e_led;
  output_display_driver #(.SCAN_DIV(S), .BLANK_LZ(1'b1), .FLASH_FRAMES(F)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr_in(addr_in), .data_valid(data_valid),
    .data_ready(data_ready), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .led(led));
  output_display_driver #(.SCAN_DIV(S), .BLANK_LZ(1'b0), .FLASH_FRAMES(F)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr_in(addr_in), .data_valid(data_valid),
    .data_ready(data_ready0), .an_n(an_n0), .seg_n(seg_n0), .dp_n(dp_n0), .led(led0));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void digit_view(input int d, input bit blz, output logic [7:0] an, output logic [6:0] seg);
    bit blanked = blz && d > 0 && 64'(disp_m) < (64'd1 << (4 * d));
    an  = blanked ? 8'hFF : ~(8'd1 << d);
    seg = blanked ? 7'h7F : hex_tab[(disp_m / (32'd1 << (4 * d))) % 16];
  endfunction
  task automatic model_reset();
    n = 0; flash_m = 0; disp_m = 0; pend_m = 0; daddr_m = 0; paddr_m = 0; pend_full_m = 0; acc_m = 0;
  endtask
  task automatic cycle();
    int d;
    bit frame;
    chk("ready", data_ready, !pend_full_m);
    chk("ready_nolz", data_ready0, !pend_full_m);
    @(posedge clk);
    d     = (n / S) % 8;
    frame = (n % (8 * S)) == 8 * S - 1;
    digit_view(d, 1'b1, e_an, e_seg);
    digit_view(d, 1'b0, e_an0, e_seg0);
    e_dp  = !(d == 0 && flash_m != 0);
    e_led = daddr_m;
    acc_m = data_valid && !pend_full_m;
    if (frame && pend_full_m) begin
      disp_m = pend_m; daddr_m = paddr_m; pend_full_m = 0; flash_m = F;
    end else if (frame && flash_m > 0) flash_m--;
    if (acc_m) begin
      pend_m = data_in; paddr_m = addr_in; pend_full_m = 1;
    end
    n++;
    @(negedge clk);
    chk("an_n", an_n, e_an);
    chk("seg_n", seg_n, e_seg);
    chk("dp_n", dp_n, e_dp);
    chk("led", led, e_led);
    chk("an_n_nolz", an_n0, e_an0);
    chk("seg_n_nolz", seg_n0, e_seg0);
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_an"}, an_n, 8'hFF);
    chk({tag, "_seg"}, seg_n, 7'h7F);
    chk({tag, "_dp"}, dp_n, 1'b1);
    chk({tag, "_led"}, led, 5'd0);
    chk({tag, "_ready"}, data_ready, 1'b1);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks("rst_async");
    repeat (2) @(negedge clk);
    reset_checks("rst_hold");
    rst_n = 1'b1;
  endtask
  task automatic send(input logic [31:0] w, input logic [4:0] a);
    data_valid = 1'b1; data_in = w; addr_in = a;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (acc_m) break;
    end
    chk("send_accepted", acc_m, 1'b1);
    data_valid = 1'b0; data_in = $urandom; addr_in = 5'($urandom);
  endtask
  task automatic idle(input int k);
    repeat (k) cycle();
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    idle(40);
    send(32'h1234ABCD, 5'd5);
    idle(100);
    send(32'h000000F0, 5'd9);
    idle(70);
    send(32'hA5A5_0001, 5'd3);
    send(32'h0000_0B00, 5'd17);
    idle(80);
    send(32'h0000_0B00, 5'd17);
    idle(70);
    send(32'hDEAD_BEEF, 5'd30);
    idle(6);
    do_reset();
    idle(70);
    for (int t = 0; t < 40; t++) begin
      send($urandom >> $urandom_range(0, 31), 5'($urandom));
      idle($urandom_range(0, 40));
    end
    idle(70);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
